// File: rtl/ieee_sd_arbiter.sv
// Round-robin arbiter sharing one SD host port among NREQ block-device requesters.
// Optional transfer watchdog is enabled by defining IEEE_SD_TIMEOUT_EN.
module ieee_sd_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_rd,
    input  logic [NREQ-1:0]        req_wr,
    input  logic [32*NREQ-1:0]     req_lba,
    input  logic [6*NREQ-1:0]      req_blk_cnt,
    input  logic [8*NREQ-1:0]      req_buff_din,
    output logic [NREQ-1:0]        req_ack,
    output logic [NREQ-1:0]        req_done,
    output logic [31:0]            sd_lba,
    output logic [5:0]             sd_blk_cnt,
    output logic                   sd_rd,
    output logic                   sd_wr,
    input  logic                   sd_ack,
    output logic [7:0]             sd_buff_din,
    output logic                   timeout
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef logic [IdxW-1:0] idx_t;
    typedef enum logic [1:0] {StIdle, StIssue, StXfer, StDone} state_e;

    if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
        $error("ieee_sd_arbiter: NREQ must be in 1..8");
    end

    state_e      state_q, state_d;
    idx_t        g_q, g_d;
    idx_t        lg_q, lg_d;
    logic        rd_dir_q, rd_dir_d;
    logic [31:0] lba_q, lba_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        ack_q;

    logic [NREQ-1:0] req_any;
    logic            grant_vld;
    idx_t            grant_idx;
    idx_t            cand;
    logic            expired;

    logic [31:0] lba_arr  [NREQ];
    logic [5:0]  cnt_arr  [NREQ];
    logic [7:0]  buff_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign lba_arr[i]  = req_lba[32*i +: 32];
        assign cnt_arr[i]  = req_blk_cnt[6*i +: 6];
        assign buff_arr[i] = req_buff_din[8*i +: 8];
    end

    assign req_any = req_rd | req_wr;

    // Search starts one past the last grant, so a requester just served ranks last.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = lg_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (cand == idx_t'(NREQ - 1)) ? '0 : cand + idx_t'(1);
            if (!grant_vld && req_any[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

`ifdef IEEE_SD_TIMEOUT_EN
    logic [23:0] tmo_q;

    // Restarts on every state change, so it measures time spent in a single phase.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else if (state_d != state_q) begin
            tmo_q <= '0;
        end else if (state_q == StIssue || state_q == StXfer) begin
            tmo_q <= tmo_q + 24'd1;
        end
    end

    assign expired = (state_q == StIssue || state_q == StXfer) && (&tmo_q);
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        lg_d     = lg_q;
        rd_dir_d = rd_dir_q;
        lba_d    = lba_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    state_d  = StIssue;
                    g_d      = grant_idx;
                    rd_dir_d = req_rd[grant_idx];
                    lba_d    = lba_arr[grant_idx];
                    cnt_d    = cnt_arr[grant_idx];
                end
            end
            StIssue: begin
                if (expired) begin
                    state_d = StIdle;
                    lg_d    = g_q;
                end else if (sd_ack) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (expired) begin
                    state_d = StIdle;
                    lg_d    = g_q;
                end else if (!sd_ack) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                lg_d    = g_q;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            g_q      <= '0;
            lg_q     <= idx_t'(NREQ - 1);
            rd_dir_q <= 1'b0;
            lba_q    <= '0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            lg_q     <= lg_d;
            rd_dir_q <= rd_dir_d;
            lba_q    <= lba_d;
            cnt_q    <= cnt_d;
            ack_q    <= sd_ack;
        end
    end

    // Outputs decode from registered state, so an asserted reset clears them at once.
    always_comb begin
        sd_rd       = (state_q == StIssue) && rd_dir_q && !expired;
        sd_wr       = (state_q == StIssue) && !rd_dir_q && !expired;
        req_ack     = '0;
        req_done    = '0;
        sd_buff_din = '0;
        if (state_q == StXfer) begin
            req_ack[g_q] = ack_q;
            sd_buff_din  = buff_arr[g_q];
        end
        if (state_q == StDone || expired) begin
            req_done[g_q] = 1'b1;
        end
        timeout    = expired;
        sd_lba     = lba_q;
        sd_blk_cnt = cnt_q;
    end

endmodule
